mdl_abspgdecoder: RTL and testbench

// Bit-serial receiver/decoder for the absolute page counter stream. Deserializes the 12-bit page

---
 rtl/mdl_abspgdecoder.sv | 171 +++++++++++++++++
 tb/tb_mdl_abspgdecoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdl_abspgdecoder.sv
// mdl_abspgdecoder: bit-serial absolute page counter receiver and page-search sequencer.
// Shifts in a PG_W-bit page number LSB first during ring slots 0..PG_W-1, latches it on
// slot PG_W, and drives the counter's CNT_START/CNT_STOP controls to stop on a target page.
// Optional feature macro: ABSPGDEC_ERRCNT_EN builds the saturating out-of-range frame counter;
// without it o_PG_ERRCNT is tied to 0.
module mdl_abspgdecoder #(
    parameter int PG_W    = 12,
    parameter int MODULUS = 2053,
    parameter int TIMEOUT = 2053
) (
    input  logic            i_MCLK,
    input  logic            i_RST,
    input  logic            i_CLK2M_PCEN_n,
    input  logic [19:0]     i_ROT20_n,
    input  logic            i_ABSPGCNTR_LSB,
    input  logic [PG_W-1:0] i_TARGET_PG,
    input  logic            i_SEARCH_START,
    input  logic            i_SEARCH_ABORT,
    output logic [PG_W-1:0] o_ABSPG,
    output logic            o_ABSPG_VLD,
    output logic            o_PG_ERR,
    output logic [7:0]      o_PG_ERRCNT,
    output logic            o_ABSPGCNTR_CNT_START,
    output logic            o_ABSPGCNTR_CNT_STOP,
    output logic [1:0]      o_STATE
);

    localparam int FC_W = $clog2(TIMEOUT + 1);
    localparam logic [PG_W:0]   MOD_V   = (PG_W + 1)'(MODULUS);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_HIT     = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    logic            en;
    logic            shift_slot;
    logic            latch_slot;
    logic            shift_en;
    logic            latch_en;
    logic            start_acc;
    logic            pg_oor;
    logic            pg_match;
    logic            unused_rot;

    logic [PG_W-1:0] shreg_q, shreg_d;
    logic [PG_W-1:0] abspg_q, abspg_d;
    logic            vld_q, vld_d;
    logic            err_q, err_d;
    logic            cnt_start_q, cnt_start_d;
    logic [FC_W-1:0] framecnt_q, framecnt_d;
    state_t          state_q, state_d;

    // Slots above the latch slot carry no information for this block.
    assign unused_rot = &i_ROT20_n[19:PG_W+1];

    // Enable and slot decode; the ring is active-low one-hot.
    assign en         = ~i_CLK2M_PCEN_n;
    assign shift_slot = ~(&i_ROT20_n[PG_W-1:0]);
    assign latch_slot = ~i_ROT20_n[PG_W];
    assign shift_en   = en & shift_slot;
    assign latch_en   = en & latch_slot;
    assign start_acc  = en & ~i_SEARCH_ABORT & i_SEARCH_START;

    // Range check and compare act on the freshly completed shift register, so a hit is
    // recognised on the same enable that latches the page.
    assign pg_oor   = ({1'b0, shreg_q} >= MOD_V);
    assign pg_match = (shreg_q == i_TARGET_PG) && !pg_oor;

    // Deserializer and frame latch.
    always_comb begin
        shreg_d = shreg_q;
        abspg_d = abspg_q;
        err_d   = err_q;
        vld_d   = latch_en;
        if (shift_en) begin
            shreg_d = {i_ABSPGCNTR_LSB, shreg_q[PG_W-1:1]};
        end
        if (latch_en) begin
            abspg_d = shreg_q;
            err_d   = pg_oor;
        end
    end

    // Search sequencer: ABORT beats START beats the frame event, all gated by the enable.
    always_comb begin
        state_d     = state_q;
        framecnt_d  = framecnt_q;
        cnt_start_d = cnt_start_q;
        if (en) begin
            cnt_start_d = 1'b0;
            if (i_SEARCH_ABORT) begin
                state_d    = ST_IDLE;
                framecnt_d = '0;
            end else if (i_SEARCH_START) begin
                state_d     = ST_ARMED;
                framecnt_d  = '0;
                cnt_start_d = 1'b1;
            end else if (latch_slot && (state_q == ST_ARMED)) begin
                if (pg_match) begin
                    state_d = ST_HIT;
                end else if (framecnt_q == FC_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    framecnt_d = framecnt_q + 1'b1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            shreg_q     <= '0;
            abspg_q     <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_start_q <= 1'b0;
            framecnt_q  <= '0;
            state_q     <= ST_IDLE;
        end else begin
            shreg_q     <= shreg_d;
            abspg_q     <= abspg_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            cnt_start_q <= cnt_start_d;
            framecnt_q  <= framecnt_d;
            state_q     <= state_d;
        end
    end

`ifdef ABSPGDEC_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Saturating out-of-range frame counter, restarted with each accepted search.
    always_comb begin
        errcnt_d = errcnt_q;
        if (start_acc) begin
            errcnt_d = '0;
        end else if (latch_en && pg_oor && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign o_PG_ERRCNT = errcnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign o_PG_ERRCNT      = '0;
`endif

    assign o_ABSPG               = abspg_q;
    assign o_ABSPG_VLD           = vld_q;
    assign o_PG_ERR              = err_q;
    assign o_ABSPGCNTR_CNT_START = cnt_start_q;
    assign o_ABSPGCNTR_CNT_STOP  = (state_q == ST_HIT);
    assign o_STATE               = state_q;

endmodule

// File: tb/tb_mdl_abspgdecoder.sv
// Directed bench for mdl_abspgdecoder: frame decode, search hit, range errors,
// timeout, START/ABORT priority and mid-frame reset.
module tb_mdl_abspgdecoder;

`ifdef ABSPGDEC_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en_n;
    logic [19:0] rot;
    logic        lsb;
    logic [11:0] target;
    logic        start;
    logic        abort;

    logic [11:0] abspg;
    logic        vld;
    logic        pg_err;
    logic [7:0]  errcnt;
    logic        cnt_start;
    logic        cnt_stop;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;
    int start_hi = 0;

    mdl_abspgdecoder dut (
        .i_MCLK                (clk),
        .i_RST                 (rst),
        .i_CLK2M_PCEN_n        (en_n),
        .i_ROT20_n             (rot),
        .i_ABSPGCNTR_LSB       (lsb),
        .i_TARGET_PG           (target),
        .i_SEARCH_START        (start),
        .i_SEARCH_ABORT        (abort),
        .o_ABSPG               (abspg),
        .o_ABSPG_VLD           (vld),
        .o_PG_ERR              (pg_err),
        .o_PG_ERRCNT           (errcnt),
        .o_ABSPGCNTR_CNT_START (cnt_start),
        .o_ABSPGCNTR_CNT_STOP  (cnt_stop),
        .o_STATE               (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cnt_start) start_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        if (!ERRCNT_ON) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // One enabled MCLK cycle with the given slot active (-1: no slot).
    task automatic step(input int slot, input logic b);
        rot  = (slot < 0) ? 20'hFFFFF : ~(20'd1 << slot);
        lsb  = b;
        en_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] v, input bit full);
        for (int k = 0; k < 12; k++) step(k, v[k]);
        step(12, 1'b1);
        if (full) for (int k = 13; k < 20; k++) step(k, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(-1, 1'b1);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_abspg"}, 32'(abspg), 32'd0);
        chk({tag, "_vld"}, 32'(vld), 32'd0);
        chk({tag, "_err"}, 32'(pg_err), 32'd0);
        chk({tag, "_errcnt"}, 32'(errcnt), 32'd0);
        chk({tag, "_cstart"}, 32'(cnt_start), 32'd0);
        chk({tag, "_cstop"}, 32'(cnt_stop), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en_n = 1'b1; rot = 20'hFFFFF; lsb = 1'b0;
        target = 12'd0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic decode of 0x20A, with junk LSB in non-shift slots.
        for (int k = 0; k < 12; k++) step(k, 1'(12'h20A >> k));
        step(12, 1'b1);
        chk("dec_vld_hi", 32'(vld), 32'd1);
        chk("dec_abspg", 32'(abspg), 32'h20A);
        chk("dec_err", 32'(pg_err), 32'd0);
        step(13, 1'b1);
        chk("dec_vld_lo", 32'(vld), 32'd0);
        for (int k = 14; k < 20; k++) step(k, 1'b1);

        // Slot 12 without enable must not latch.
        for (int k = 0; k < 12; k++) step(k, 1'(12'h123 >> k));
        rot = ~(20'd1 << 12); en_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("gate_vld", 32'(vld), 32'd0);
        chk("gate_abspg", 32'(abspg), 32'h20A);
        step(12, 1'b1);
        chk("gate_latch", 32'(abspg), 32'h123);

        // Search for 1044.
        target = 12'd1044;
        start_hi = 0;
        pulse_start();
        chk("srch_cstart", 32'(cnt_start), 32'd1);
        chk("srch_armed", 32'(state), 32'd1);
        send_frame(12'd0, 1'b0);
        chk("srch_f1_state", 32'(state), 32'd1);
        chk("srch_f1_stop", 32'(cnt_stop), 32'd0);
        send_frame(12'd522, 1'b0);
        chk("srch_f2_state", 32'(state), 32'd1);
        send_frame(12'd1044, 1'b0);
        chk("srch_hit_state", 32'(state), 32'd2);
        chk("srch_hit_stop", 32'(cnt_stop), 32'd1);
        chk("srch_hit_pg", 32'(abspg), 32'd1044);
        chk("srch_start_cnt", 32'(start_hi), 32'd1);
        send_frame(12'd0, 1'b0);
        chk("srch_hold", 32'(state), 32'd2);

        // Out-of-range pages and the MODULUS boundary.
        send_frame(12'hFFF, 1'b0);
        chk("oor_err", 32'(pg_err), 32'd1);
        chk("oor_cnt1", 32'(errcnt), 32'(exp_cnt(1)));
        send_frame(12'd2052, 1'b0);
        chk("bnd_2052_err", 32'(pg_err), 32'd0);
        send_frame(12'd2053, 1'b0);
        chk("bnd_2053_err", 32'(pg_err), 32'd1);
        chk("bnd_cnt2", 32'(errcnt), 32'(exp_cnt(2)));
        for (int i = 0; i < 298; i++) send_frame(12'hFFF, 1'b0);
        chk("sat_cnt", 32'(errcnt), 32'(exp_cnt(300)));

        // Timeout with an unreachable target; 2060 frames are out of range and never match.
        target = 12'd2060;
        pulse_start();
        chk("to_cnt_clr", 32'(errcnt), 32'd0);
        for (int i = 1; i <= 2053; i++) begin
            send_frame((i % 100 == 0) ? 12'd2060 : ((i % 7 == 0) ? 12'hFFF : 12'd5), 1'b0);
            if (i == 2052) chk("to_f2052", 32'(state), 32'd1);
        end
        chk("to_f2053", 32'(state), 32'd3);
        chk("to_stop", 32'(cnt_stop), 32'd0);
        send_frame(12'd5, 1'b0);
        chk("to_hold", 32'(state), 32'd3);
        abort = 1'b1;
        step(-1, 1'b1);
        abort = 1'b0;
        chk("abort_idle", 32'(state), 32'd0);

        // START and ABORT together while ARMED.
        pulse_start();
        chk("sa_armed", 32'(state), 32'd1);
        start = 1'b1; abort = 1'b1;
        step(-1, 1'b1);
        start = 1'b0; abort = 1'b0;
        chk("sa_state", 32'(state), 32'd0);
        chk("sa_cstart", 32'(cnt_start), 32'd0);

        // Reset after slot 5, then a clean frame.
        for (int k = 0; k < 6; k++) step(k, 1'(12'hABC >> k));
        #1;
        rst = 1'b1;
        en_n = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        send_frame(12'h5A5, 1'b1);
        chk("post_rst_pg", 32'(abspg), 32'h5A5);
        chk("post_rst_err", 32'(pg_err), 32'd0);
        chk("post_rst_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
